// File: rtl/rx_serial_7e1_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_serial_7e1_if
//  Description : Bundle of the serial line, host handshake and debug signals
//                of the 7E1 receiver.
//                slave  modport : receiver side (drives character/status)
//                master modport : host/line side (drives line and acknowledge)
//  Signals     : dado_serial    serial line, idle high, LSB first
//                recebe_dado    one-cycle acknowledge, clears tem_dado
//                dados_ascii[7] last received character
//                paridade_ok    last character had even parity
//                erro_stop      last character's stop bit was 0
//                pronto         one-cycle pulse when a character is stored
//                tem_dado       unread character available
//                db_dado_serial synchronized line value
//                db_tick        sampling strobe
//                db_estado[4]   FSM state code
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_serial_7e1_if;
    logic       dado_serial;
    logic       recebe_dado;
    logic [6:0] dados_ascii;
    logic       paridade_ok;
    logic       erro_stop;
    logic       pronto;
    logic       tem_dado;
    logic       db_dado_serial;
    logic       db_tick;
    logic [3:0] db_estado;

    modport slave (
        input  dado_serial,
        input  recebe_dado,
        output dados_ascii,
        output paridade_ok,
        output erro_stop,
        output pronto,
        output tem_dado,
        output db_dado_serial,
        output db_tick,
        output db_estado
    );

    modport master (
        output dado_serial,
        output recebe_dado,
        input  dados_ascii,
        input  paridade_ok,
        input  erro_stop,
        input  pronto,
        input  tem_dado,
        input  db_dado_serial,
        input  db_tick,
        input  db_estado
    );
endinterface
`default_nettype wire

// File: rtl/rx_serial_7e1.sv
`default_nettype none
// ============================================================================
//  Module      : rx_serial_7e1
//  Description : Asynchronous serial receiver, 7 data bits, even parity,
//                1 stop bit. Default timing is 115200 baud at 50 MHz.
//  Ports       : clock  system clock
//                reset  synchronous, active-high reset
//                bus    rx_serial_7e1_if.slave (line, handshake, status, debug)
//  Parameters  : M  clock cycles per bit
//                N  width of the bit-period counter (2**N > M)
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_serial_7e1 #(
    parameter int M = 434,
    parameter int N = 9
) (
    input  wire             clock,
    input  wire             reset,
    rx_serial_7e1_if.slave  bus
);

    localparam logic [3:0] S_INICIAL  = 4'd0;
    localparam logic [3:0] S_INICIO   = 4'd1;
    localparam logic [3:0] S_ESPERA   = 4'd2;
    localparam logic [3:0] S_AMOSTRA  = 4'd3;
    localparam logic [3:0] S_ARMAZENA = 4'd4;
    localparam logic [3:0] S_FINAL    = 4'd5;

    // Half-bit terminal count: INICIO spends M/2 cycles (0 .. M/2-1).
    localparam logic [N-1:0] HALF_TC = N'(M / 2 - 1);
    // ESPERA + the single AMOSTRA cycle together make one bit period of M.
    localparam logic [N-1:0] WAIT_TC = N'(M - 2);
    localparam logic [N-1:0] CNT_ONE = N'(1);

    // Two-flop synchronizer, reset to the idle (high) line level
    logic sync_meta_q;
    logic serial_q;

    logic [3:0]   state_q, state_d;
    logic [N-1:0] cnt_q,   cnt_d;
    logic [3:0]   bitcnt_q, bitcnt_d;
    logic [8:0]   sh_q,    sh_d;

    logic [6:0]   dados_q;
    logic         par_ok_q;
    logic         erro_stop_q;
    logic         tem_dado_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta_q <= 1'b1;
            serial_q    <= 1'b1;
        end else begin
            sync_meta_q <= bus.dado_serial;
            serial_q    <= sync_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        sh_d     = sh_q;
        case (state_q)
            S_INICIAL: begin
                if (!serial_q) begin
                    cnt_d   = '0;
                    state_d = S_INICIO;
                end
            end
            S_INICIO: begin
                if (cnt_q == HALF_TC) begin
                    cnt_d = '0;
                    // Line back high at mid start bit means it was a glitch
                    if (serial_q) begin
                        state_d = S_INICIAL;
                    end else begin
                        bitcnt_d = '0;
                        state_d  = S_ESPERA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ESPERA: begin
                if (cnt_q == WAIT_TC) begin
                    cnt_d   = '0;
                    state_d = S_AMOSTRA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_AMOSTRA: begin
                // LSB arrives first, so shift right and enter at the MSB
                sh_d     = {serial_q, sh_q[8:1]};
                bitcnt_d = bitcnt_q + 4'd1;
                state_d  = (bitcnt_q == 4'd8) ? S_ARMAZENA : S_ESPERA;
            end
            S_ARMAZENA: begin
                state_d = S_FINAL;
            end
            S_FINAL: begin
                state_d = S_INICIAL;
            end
            default: begin
                state_d = S_INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_INICIAL;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            sh_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            sh_q     <= sh_d;
        end
    end

    // Output register: only ARMAZENA updates the character and status.
    // A store while tem_dado is already set silently overwrites (overrun).
    always_ff @(posedge clock) begin
        if (reset) begin
            dados_q     <= '0;
            par_ok_q    <= 1'b0;
            erro_stop_q <= 1'b0;
            tem_dado_q  <= 1'b0;
        end else begin
            if (state_q == S_ARMAZENA) begin
                dados_q     <= sh_q[6:0];
                par_ok_q    <= ~^sh_q[7:0];
                erro_stop_q <= ~sh_q[8];
            end
            // Store has priority over a simultaneous acknowledge
            if (state_q == S_ARMAZENA) begin
                tem_dado_q <= 1'b1;
            end else if (bus.recebe_dado) begin
                tem_dado_q <= 1'b0;
            end
        end
    end

    assign bus.dados_ascii    = dados_q;
    assign bus.paridade_ok    = par_ok_q;
    assign bus.erro_stop      = erro_stop_q;
    assign bus.tem_dado       = tem_dado_q;
    assign bus.pronto         = (state_q == S_ARMAZENA);
    assign bus.db_tick        = (state_q == S_AMOSTRA);
    assign bus.db_dado_serial = serial_q;
    assign bus.db_estado      = state_q;

endmodule
`default_nettype wire
